// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling, ready/ack holding register,
// framing-error pulse and sticky overrun flag.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk_50mhz,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  input  logic       data_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_rx_s;
  logic             w_half;
  logic             w_last;
  assign w_rx_s = r_sync[1];
  assign w_half = r_cnt == LP_HALF;
  assign w_last = r_cnt == LP_LAST;
  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end
  // An ack clears the holding register unless a new byte lands the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready & ~data_ack;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_rx_s ? IDLE : START;
      end
      START: begin
        if (w_half) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = (r_idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_data_nxt  = w_rx_s ? r_shift : r_data;
          w_ready_nxt = w_rx_s | (r_ready & ~data_ack);
          w_ovr_nxt   = r_ovr | (w_rx_s & r_ready & ~data_ack);
          w_ferr_nxt  = ~w_rx_s;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  assign data          = r_data;
  assign data_ready    = r_ready;
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;
  assign busy          = r_state != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench; each frame attempt pushes its expected outcome,
// and a monitor checks it when busy falls.
module tb_uart_receiver;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] d;
    logic       r;
    logic       o;
    logic       f;
    int         lat;
  } exp_t;
  logic       clk_50mhz = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;
  exp_t       q[$];
  int         cyc = 0;
  int         t_start = 0;
  bit         rst_done = 1'b0;
  bit         done = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk_50mhz(clk_50mhz),
    .reset_n(reset_n),
    .rx(rx),
    .data(data),
    .data_ready(data_ready),
    .data_ack(data_ack),
    .framing_error(framing_error),
    .overrun(overrun),
    .busy(busy)
  );
  always #5 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc <= cyc + 1;
  task automatic push(input logic [7:0] d, input logic r, input logic o, input logic f, input int lat);
    exp_t e;
    e.d = d;
    e.r = r;
    e.o = o;
    e.f = f;
    e.lat = lat;
    q.push_back(e);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at, input int n);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < n; i++) begin
      rx = bits[i/CPB];
      data_ack = (i == ack_at);
      @(posedge clk_50mhz);
      #1;
    end
    data_ack = 1'b0;
    rx = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask
  task automatic ack;
    data_ack = 1'b1;
    @(posedge clk_50mhz);
    #1;
    data_ack = 1'b0;
  endtask
  initial begin
    idle(3);
    reset_n = 1'b1;
    rst_done = 1'b1;
    idle(5);
    push(8'hA5, 1, 0, 0, 155);
    send_frame(8'hA5, 1, -1, 160);
    ack;
    idle(20);
    push(8'h00, 1, 0, 0, 155);
    push(8'hFF, 1, 0, 0, 155);
    send_frame(8'h00, 1, -1, 160);
    send_frame(8'hFF, 1, 5, 160);
    ack;
    idle(20);
    push(8'h3C, 1, 0, 0, 155);
    push(8'hC3, 1, 1, 0, 155);
    send_frame(8'h3C, 1, -1, 160);
    send_frame(8'hC3, 1, -1, 160);
    idle(10);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(10);
    push(8'h3C, 1, 0, 0, 155);
    push(8'hC3, 1, 0, 0, 155);
    send_frame(8'h3C, 1, -1, 160);
    send_frame(8'hC3, 1, 154, 160);
    ack;
    idle(20);
    push(8'hC3, 0, 0, 1, 155);
    push(8'hC3, 0, 0, 0, 164);
    send_frame(8'h55, 0, -1, 160);
    idle(40);
    push(8'hC3, 0, 0, 0, 11);
    send_frame(8'hFF, 1, -1, 4);
    idle(40);
    push(8'h00, 0, 0, 0, -1);
    send_frame(8'h81, 1, -1, 60);
    rx = 1'b1;
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(20);
    push(8'h81, 1, 0, 0, 155);
    send_frame(8'h81, 1, -1, 160);
    ack;
    idle(40);
    done = 1'b1;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    logic pb, pr;
    int   ferr_cnt, rise_cnt;
    ferr_cnt = 0;
    rise_cnt = 0;
    wait (rst_done);
    @(negedge clk_50mhz);
    chk("reset data", int'(data), 0);
    chk("reset data_ready", int'(data_ready), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset framing_error", int'(framing_error), 0);
    chk("reset busy", int'(busy), 0);
    pb = busy;
    pr = data_ready;
    while (!done) begin
      @(negedge clk_50mhz);
      if (framing_error === 1'b1) ferr_cnt++;
      if (data_ready === 1'b1 && pr === 1'b0) rise_cnt++;
      if (busy === 1'b1 && pb === 1'b0 && cyc - t_start <= 8)
        chk("busy rise latency", cyc - t_start, 3);
      if (busy === 1'b0 && pb === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected frame end: data %0h ready %0b", data, data_ready);
        end else begin
          e = q.pop_front();
          chk("data", int'(data), int'(e.d));
          chk("data_ready", int'(data_ready), int'(e.r));
          chk("overrun", int'(overrun), int'(e.o));
          chk("framing_error", int'(framing_error), int'(e.f));
          if (e.lat >= 0) chk("frame end latency", cyc - t_start, e.lat);
        end
      end
      pb = busy;
      pr = data_ready;
    end
    chk("framing_error pulse count", ferr_cnt, 1);
    chk("data_ready rise count", rise_cnt, 6);
    chk("pending expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
